// File: rtl/data_mem_pkg.sv
// Shared definitions for the parametrised data memory.
// Holds the read-during-write mode constants, the controller state encoding
// and the byte-lane merge helper used for partial-word writes.
// No ports (package).
package data_mem_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // The merge helper works on the widest supported word; callers zero-extend
   // their operands and truncate the result back to their own width.
   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } mem_state_t;

   // Replace each byte lane of old_word whose enable bit is set by the
   // corresponding lane of new_word.
   function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BYTES-1:0]      lane_en
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (lane_en[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Request/response bundle between the MEM stage and the data memory.
// master: drives address, write_data, byte_en, mem_read, mem_write;
//         receives read_data, read_valid, addr_error, busy.
// slave : the memory side, directions reversed.
interface data_memory_param_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) ();

   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH-1:0]   write_data;
   logic [DATA_WIDTH/8-1:0] byte_en;
   logic                    mem_read;
   logic                    mem_write;
   logic [DATA_WIDTH-1:0]   read_data;
   logic                    read_valid;
   logic                    addr_error;
   logic                    busy;

   modport master (
      output address, write_data, byte_en, mem_read, mem_write,
      input  read_data, read_valid, addr_error, busy
   );

   modport slave (
      input  address, write_data, byte_en, mem_read, mem_write,
      output read_data, read_valid, addr_error, busy
   );

endinterface

// File: rtl/read_delay_pipe.sv
// LATENCY-stage shift register carrying {valid, data} for read results.
// Ports: clk, rst (sync clear of all stages), in_valid/in_data (stage 0
// input), out_valid/out_data (last stage). Data stages only advance when
// the stage feeding them is valid, so out_data holds the last delivered
// word while out_valid is low.
module read_delay_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  valid_sr [LATENCY];
   logic [DATA_WIDTH-1:0] data_sr  [LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            valid_sr[i] <= 1'b0;
            data_sr[i]  <= '0;
         end
      end else begin
         valid_sr[0] <= in_valid;
         if (in_valid) begin
            data_sr[0] <= in_data;
         end
         for (int i = 1; i < LATENCY; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            if (valid_sr[i-1]) begin
               data_sr[i] <= data_sr[i-1];
            end
         end
      end
   end

   assign out_valid = valid_sr[LATENCY-1];
   assign out_data  = data_sr[LATENCY-1];

endmodule

// File: rtl/data_memory_param.sv
// Parametrised word-addressed data memory for the 16-bit CPU datapath.
// Ports: clk, rst (sync, active-high), bus (data_memory_param_if.slave):
//   address/write_data/byte_en/mem_read/mem_write in,
//   read_data/read_valid out through a READ_LATENCY-deep pipeline,
//   addr_error (registered, one cycle per out-of-range request),
//   busy (high while the post-reset clear sequence runs).
// DATA_WIDTH must be a multiple of 8 and at most 64.
module data_memory_param
   import data_mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 16,
   parameter int DEPTH         = 256,
   parameter int READ_LATENCY  = 1,
   parameter int RDW_MODE      = RDW_OLD,
   parameter int INIT_ON_RESET = 1
) (
   input  logic               clk,
   input  logic               rst,
   data_memory_param_if.slave bus
);

   localparam int                  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   mem_state_t            state;
   logic [IDX_W-1:0]      clr_cnt;
   logic                  busy_q;
   logic                  addr_error_q;

   logic                  in_range;
   logic                  accept_rd;
   logic                  accept_wr;
   logic                  req_error;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged_word;
   logic [DATA_WIDTH-1:0] pipe_in_data;
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data;

   // Upper address bits are never wrapped: the extra bit on the compare
   // lets DEPTH equal 2**ADDR_WIDTH.
   assign in_range  = ({1'b0, bus.address} < DEPTH_LIMIT);
   assign word_idx  = bus.address[IDX_W-1:0];
   assign accept_rd = !rst && !busy_q && in_range && bus.mem_read;
   assign accept_wr = !rst && !busy_q && in_range && bus.mem_write;
   assign req_error = !busy_q && !in_range && (bus.mem_read || bus.mem_write);

   assign old_word    = mem[word_idx];
   assign merged_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word),
                                               MAX_DATA_WIDTH'(bus.write_data),
                                               MAX_BYTES'(bus.byte_en)));

   // A simultaneous read of the word being written sees either the stored
   // word or the merged word that the write is about to store.
   assign pipe_in_data = (RDW_MODE == RDW_NEW && accept_wr) ? merged_word : old_word;

   // Single write port shared by the clear sequence and normal writes;
   // requests cannot be accepted while clearing, so they never collide.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = word_idx;
      wr_word = merged_word;
      if (state == CLEAR && !rst) begin
         wr_en   = 1'b1;
         wr_idx  = clr_cnt;
         wr_word = '0;
      end else if (accept_wr) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_word;
      end
   end

   // Controller: CLEAR walks clr_cnt over every word, then drops to IDLE.
   // busy is registered alongside the state so it falls the cycle after the
   // last word is cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
         busy_q       <= (INIT_ON_RESET != 0);
         clr_cnt      <= '0;
         addr_error_q <= 1'b0;
      end else begin
         addr_error_q <= req_error;
         case (state)
            CLEAR: begin
               if (clr_cnt == LAST_IDX) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   read_delay_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (READ_LATENCY)
   ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept_rd),
      .in_data   (pipe_in_data),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   assign bus.read_valid = pipe_valid;
   assign bus.read_data  = pipe_data;
   assign bus.addr_error = addr_error_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param. Two instances share one stimulus stream:
// dut_a uses READ_LATENCY=1 / RDW_MODE=0, dut_b uses READ_LATENCY=3 /
// RDW_MODE=1. A reference model (plain array plus per-instance queues of
// due read results) predicts every output each cycle; directed sequences and
// a vector table add explicit expectations on top.
module tb_data_memory_param;

   localparam int DEPTH = 256;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic [15:0] write_data;
   logic [1:0]  byte_en;
   logic        mem_read;
   logic        mem_write;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if_a ();
   data_memory_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if_b ();

   assign if_a.address    = address;
   assign if_a.write_data = write_data;
   assign if_a.byte_en    = byte_en;
   assign if_a.mem_read   = mem_read;
   assign if_a.mem_write  = mem_write;
   assign if_b.address    = address;
   assign if_b.write_data = write_data;
   assign if_b.byte_en    = byte_en;
   assign if_b.mem_read   = mem_read;
   assign if_b.mem_write  = mem_write;

   data_memory_param #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH),
      .READ_LATENCY(LAT_A), .RDW_MODE(0), .INIT_ON_RESET(1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   data_memory_param #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH),
      .READ_LATENCY(LAT_B), .RDW_MODE(1), .INIT_ON_RESET(1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [15:0] data;
   } rd_item_t;

   logic [15:0] model_mem [DEPTH];
   rd_item_t    q_a[$];
   rd_item_t    q_b[$];
   logic [15:0] last_a;
   logic [15:0] last_b;
   logic        err_exp;
   int          cycle_no   = 0;
   int          clear_left = 0;
   bit          model_on   = 1'b0;

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // After reset the memory reads as all zeros once busy drops, and busy
   // lasts exactly DEPTH cycles. A read accepted at edge k shows up right
   // after edge k+L-1.
   always @(posedge clk) begin : model_blk
      logic [15:0] mask;
      logic [15:0] old_w;
      logic [15:0] new_w;
      bit          busy_now;
      bit          hit;
      cycle_no++;
      if (rst) begin
         model_on   = 1'b1;
         clear_left = DEPTH;
         err_exp    = 1'b0;
         last_a     = '0;
         last_b     = '0;
         q_a.delete();
         q_b.delete();
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else if (model_on) begin
         busy_now = (clear_left > 0);
         hit      = (address < DEPTH);
         err_exp  = !busy_now && !hit && (mem_read || mem_write);
         if (!busy_now && hit) begin
            mask  = {{8{byte_en[1]}}, {8{byte_en[0]}}};
            old_w = model_mem[address[7:0]];
            new_w = (old_w & ~mask) | (write_data & mask);
            if (mem_write) model_mem[address[7:0]] = new_w;
            if (mem_read) begin
               q_a.push_back('{due: cycle_no + LAT_A - 1, data: old_w});
               q_b.push_back('{due: cycle_no + LAT_B - 1, data: mem_write ? new_w : old_w});
            end
         end
         if (clear_left > 0) clear_left--;
      end
   end

   // Every cycle, compare both instances against the model away from the edge.
   always @(negedge clk) begin : checker_blk
      logic exp_va;
      logic exp_vb;
      if (model_on) begin
         exp_va = 1'b0;
         exp_vb = 1'b0;
         if (q_a.size() > 0 && q_a[0].due == cycle_no) begin
            exp_va = 1'b1;
            last_a = q_a[0].data;
            void'(q_a.pop_front());
         end
         if (q_b.size() > 0 && q_b[0].due == cycle_no) begin
            exp_vb = 1'b1;
            last_b = q_b[0].data;
            void'(q_b.pop_front());
         end
         check_output("busy_a",       16'(if_a.busy),       16'(clear_left > 0));
         check_output("busy_b",       16'(if_b.busy),       16'(clear_left > 0));
         check_output("addr_error_a", 16'(if_a.addr_error), 16'(err_exp));
         check_output("addr_error_b", 16'(if_b.addr_error), 16'(err_exp));
         check_output("read_valid_a", 16'(if_a.read_valid), 16'(exp_va));
         check_output("read_valid_b", 16'(if_b.read_valid), 16'(exp_vb));
         check_output("read_data_a",  if_a.read_data,       last_a);
         check_output("read_data_b",  if_b.read_data,       last_b);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a,
                                 input logic [15:0] wd, input logic [1:0] be);
      mem_read   = rd;
      mem_write  = wr;
      address    = a;
      write_data = wd;
      byte_en    = be;
   endtask

   task automatic write_word(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
      apply_stimulus(1'b0, 1'b1, a, wd, be);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, a, wd, be);
   endtask

   // Waits a fixed window after an issued request and records the first
   // read_valid of each instance and how many cycles it took.
   task automatic collect(output logic [15:0] da, output logic [15:0] db,
                          output int la, output int lb);
      la = -1;
      lb = -1;
      da = '0;
      db = '0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         if (if_a.read_valid && la < 0) begin
            la = n;
            da = if_a.read_data;
         end
         if (if_b.read_valid && lb < 0) begin
            lb = n;
            db = if_b.read_data;
         end
      end
   endtask

   task automatic read_word(input logic [15:0] a, output logic [15:0] da, output logic [15:0] db,
                            output int la, output int lb);
      apply_stimulus(1'b1, 1'b0, a, 16'h0, 2'b00);
      collect(da, db, la, lb);
   endtask

   task automatic check_read(input string name, input logic [15:0] a, input logic [15:0] exp_a,
                             input logic [15:0] exp_b);
      logic [15:0] da;
      logic [15:0] db;
      int          la;
      int          lb;
      read_word(a, da, db, la, lb);
      check_output({name, "_data_a"}, da, exp_a);
      check_output({name, "_data_b"}, db, exp_b);
      check_output({name, "_lat_a"}, 16'(la), 16'(LAT_A));
      check_output({name, "_lat_b"}, 16'(lb), 16'(LAT_B));
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (if_a.busy && n < 600) begin
         n++;
         @(negedge clk);
      end
   endtask

   // ---------------- test sequence ----------------
   typedef struct {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[7];

   initial begin : main
      logic [15:0] da;
      logic [15:0] db;
      int          la;
      int          lb;
      int          n;
      int          nv;

      vecs[0] = '{addr: 16'd5,   wdata: 16'hABCD, be: 2'b11, exp: 16'hABCD};
      vecs[1] = '{addr: 16'd5,   wdata: 16'h1234, be: 2'b01, exp: 16'hAB34};
      vecs[2] = '{addr: 16'd5,   wdata: 16'hFFFF, be: 2'b00, exp: 16'hAB34};
      vecs[3] = '{addr: 16'd5,   wdata: 16'h5600, be: 2'b10, exp: 16'h5634};
      vecs[4] = '{addr: 16'd200, wdata: 16'hBEEF, be: 2'b11, exp: 16'hBEEF};
      vecs[5] = '{addr: 16'd255, wdata: 16'h0F0F, be: 2'b10, exp: 16'h0F00};
      vecs[6] = '{addr: 16'd0,   wdata: 16'h00FF, be: 2'b01, exp: 16'h00FF};

      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] clear after reset");
      check_output("reset_busy_a", 16'(if_a.busy), 16'd1);
      wait_clear(n);
      check_output("clear_cycles", 16'(n), 16'd256);
      check_read("clr_w0",   16'd0,   16'h0000, 16'h0000);
      check_read("clr_w128", 16'd128, 16'h0000, 16'h0000);
      check_read("clr_w255", 16'd255, 16'h0000, 16'h0000);

      $display("[TB] byte-enable vector table");
      for (int i = 0; i < 7; i++) begin
         write_word(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         read_word(vecs[i].addr, da, db, la, lb);
         check_output($sformatf("vec%0d_a", i), da, vecs[i].exp);
         check_output($sformatf("vec%0d_b", i), db, vecs[i].exp);
      end

      $display("[TB] write then back-to-back reads");
      for (int i = 0; i < 30; i++) write_word(16'(i), 16'(i), 2'b11);
      for (int i = 0; i < 30; i++) begin
         apply_stimulus(1'b1, 1'b0, 16'(i), 16'h0, 2'b00);
         @(negedge clk);
         check_output("burst_valid_a", 16'(if_a.read_valid), 16'd1);
         check_output("burst_data_a", if_a.read_data, 16'(i));
      end
      mem_read = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] read during write");
      write_word(16'd7, 16'h1111, 2'b11);
      apply_stimulus(1'b1, 1'b1, 16'd7, 16'h2222, 2'b11);
      collect(da, db, la, lb);
      check_output("rdw_old_a", da, 16'h1111);
      check_output("rdw_new_b", db, 16'h2222);
      check_output("rdw_lat_b", 16'(lb), 16'(LAT_B));
      check_read("rdw_after", 16'd7, 16'h2222, 16'h2222);

      $display("[TB] out of range");
      write_word(16'd44, 16'h4444, 2'b11);
      apply_stimulus(1'b0, 1'b1, 16'd300, 16'hDEAD, 2'b11);
      @(negedge clk);
      mem_write = 1'b0;
      check_output("oor_err_a", 16'(if_a.addr_error), 16'd1);
      check_output("oor_err_b", 16'(if_b.addr_error), 16'd1);
      @(negedge clk);
      check_output("oor_err_drop_a", 16'(if_a.addr_error), 16'd0);
      check_read("oor_w44", 16'd44, 16'h4444, 16'h4444);
      check_read("lat_w3", 16'd3, 16'h0003, 16'h0003);

      $display("[TB] reset with reads in flight and mid-clear");
      write_word(16'd10, 16'h5555, 2'b11);
      write_word(16'd200, 16'h5555, 2'b11);
      apply_stimulus(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
      @(negedge clk);
      address = 16'd4;
      @(negedge clk);
      mem_read = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("rst_data_b", if_b.read_data, 16'h0000);
      nv = 0;
      for (int k = 0; k < 100; k++) begin
         if (k < 6 && if_b.read_valid) nv++;
         if (k == 10) apply_stimulus(1'b0, 1'b1, 16'd400, 16'h9999, 2'b11);
         if (k == 11) begin
            mem_write = 1'b0;
            check_output("busy_no_err_a", 16'(if_a.addr_error), 16'd0);
         end
         @(negedge clk);
      end
      check_output("flushed_valids_b", 16'(nv), 16'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_clear(n);
      check_output("restart_cycles", 16'(n), 16'd256);
      check_read("restart_w10",  16'd10,  16'h0000, 16'h0000);
      check_read("restart_w200", 16'd200, 16'h0000, 16'h0000);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0)
            address = 16'($urandom_range(256, 65535));
         else
            address = 16'($urandom_range(0, 31));
         mem_read   = 1'($urandom_range(0, 1));
         mem_write  = 1'($urandom_range(0, 1));
         write_data = 16'($urandom);
         byte_en    = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      repeat (6) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/data_memory_param.md
Name: data_memory_param

Overview:
- Parametrised next-generation data memory for the 16-bit CPU datapath; word-addressed; sits between the MEM stage and the register write-back mux.
- Adds configurable width/depth, per-byte write enables, pipelined read latency with a valid strobe, and a read-during-write mode.
- Adds out-of-range address detection and an optional hardware clear-on-reset sequence.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, width of the address port.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to read_valid; legal range 1..4.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new (merged) data.
- INIT_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- address  in  ADDR_WIDTH  word address.
- write_data  in  DATA_WIDTH  write data.
- byte_en  in  DATA_WIDTH/8  byte lane enables for writes; bit i selects bits [8i+7:8i].
- mem_read  in  1  read request.
- mem_write  in  1  write request.
- read_data  out  DATA_WIDTH  read result; valid only while read_valid=1.
- read_valid  out  1  one-cycle strobe per accepted read.
- addr_error  out  1  registered; set one cycle after a request with address ≥ DEPTH.
- busy  out  1  high while the clear sequence runs; requests are ignored while high.

Behaviour:
- Reset: rst sampled high at an edge sets read_data=0, read_valid=0, addr_error=0, and flushes the read pipeline.
  - INIT_ON_RESET=1: busy=1 in the cycle after reset.
  - INIT_ON_RESET=0: busy=0.
- FSM states, INIT_ON_RESET=1:
  - CLEAR: entered on rst. Writes 0 to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, busy=1. After the write of DEPTH-1, go to IDLE; busy falls the following cycle.
  - IDLE: normal operation.
  - INIT_ON_RESET=0: always IDLE.
- rst asserted mid-CLEAR restarts the clear from word 0. rst asserted with reads in flight discards them; no read_valid.
- Request accepted only when busy=0 and address < DEPTH.
- Write: takes effect at the accepting edge. Only lanes with byte_en[i]=1 are updated; byte_en=0 leaves the word unchanged.
- Read: samples memory at the accepting edge.
  - read_data and read_valid appear exactly READ_LATENCY cycles later, through a shift pipeline.
  - Back-to-back reads are accepted every cycle, with full throughput.
  - read_data holds its last value when read_valid=0.
- mem_read and mem_write together, same address: write performed as above. Read returns the pre-write word (RDW_MODE=0) or the byte-merged post-write word (RDW_MODE=1).
- Out-of-range (address ≥ DEPTH) with mem_read or mem_write:
  - Request dropped; no memory change and no read_valid.
  - addr_error=1 for exactly the next cycle.
  - Evaluated only when busy=0.
- Requests while busy=1 are dropped silently; addr_error stays 0.
- Address bits above clog2(DEPTH) are not wrapped; the out-of-range rule applies instead.

Decomposition:
- Shared package data_mem_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - The state encoding for IDLE and CLEAR.
  - A function computing the byte-merged word from old data, new data and byte_en.
- One natural sub-module, read_delay_pipe: a parametrised READ_LATENCY-stage shift of {valid, data} with synchronous clear.
- Storage array, FSM and clear counter stay in the top module.

Test Plan:
- Clear on reset, DEPTH=256, INIT_ON_RESET=1: after rst pulse, busy=1 for 256 cycles then 0. Reading words 0, 128 and 255 returns 0x0000 with read_valid one cycle after each request.
- Write then read, DATA_WIDTH=16, READ_LATENCY=1: write word i = i for i=0..29 with byte_en=2'b11. Then read 0..29 on consecutive cycles; read_data=i with read_valid high on 30 consecutive cycles, each one cycle after its request.
- Byte enables: write 0xABCD to word 5, then 0x1234 with byte_en=2'b01. Reading word 5 returns 0xAB34; a further write with byte_en=2'b00 leaves 0xAB34.
- Read-during-write: word 7 holds 0x1111; issue mem_read and mem_write (0x2222, byte_en=2'b11) to word 7 together. RDW_MODE=0 returns 0x1111 and RDW_MODE=1 returns 0x2222; a later read returns 0x2222.
- Out of range and latency, DEPTH=256, READ_LATENCY=3: writing to address 300 gives addr_error=1 for one cycle and no change at word 44. A read of word 3 gives read_valid exactly 3 cycles later.
- Reset mid-operation: assert rst during CLEAR at clr_cnt=100 and with two reads in flight. No read_valid appears, and the clear restarts from 0 with busy high for a full 256 cycles.
